// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : State encoding, state type and sizing helper for the
//               bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Bit counter must be able to hold values 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : start/busy/done handshake plus operand and result buses.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Combinational 1-bit full adder from two half adders and OR.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  wire logic x,
    input  wire logic y,
    input  wire logic ci,
    output logic      s,
    output logic      co
);
    logic w_p;
    logic w_g1;
    logic w_g2;

    assign w_p  = x ^ y;
    assign w_g1 = x & y;
    assign s    = w_p ^ ci;
    assign w_g2 = w_p & ci;
    assign co   = w_g1 | w_g2;
endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
//               with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input wire logic      clk,
    input wire logic      rst,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_sr_q,  w_a_sr_d;
    logic [WIDTH-1:0] r_b_sr_q,  w_b_sr_d;
    logic [WIDTH-1:0] r_s_sr_q,  w_s_sr_d;
    logic             r_carry_q, w_carry_d;
    logic [CW-1:0]    r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_sum_q,   w_sum_d;
    logic             r_cout_q,  w_cout_d;

    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_last;
    logic [WIDTH-1:0] w_s_shift;

    fa_cell u_fa_cell (
        .x  (r_a_sr_q[0]),
        .y  (r_b_sr_q[0]),
        .ci (r_carry_q),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_last    = (r_cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; works for WIDTH=1 as well.
    assign w_s_shift = WIDTH'({w_fa_s, r_s_sr_q} >> 1);

    always_comb begin
        w_state_d = r_state_q;
        w_a_sr_d  = r_a_sr_q;
        w_b_sr_d  = r_b_sr_q;
        w_s_sr_d  = r_s_sr_q;
        w_carry_d = r_carry_q;
        w_cnt_d   = r_cnt_q;
        w_sum_d   = r_sum_q;
        w_cout_d  = r_cout_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_a_sr_d  = bus.a;
                    w_b_sr_d  = bus.b;
                    w_carry_d = bus.cin;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end else begin
                    w_state_d = S_IDLE;
                end
            end

            S_RUN: begin
                w_a_sr_d  = r_a_sr_q >> 1;
                w_b_sr_d  = r_b_sr_q >> 1;
                w_s_sr_d  = w_s_shift;
                w_carry_d = w_fa_co;
                w_cnt_d   = r_cnt_q + CW'(1);
                if (w_last) begin
                    w_sum_d   = w_s_shift;
                    w_cout_d  = w_fa_co;
                    w_state_d = S_DONE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_a_sr_q  <= '0;
            r_b_sr_q  <= '0;
            r_s_sr_q  <= '0;
            r_carry_q <= 1'b0;
            r_cnt_q   <= '0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_sr_q  <= w_a_sr_d;
            r_b_sr_q  <= w_b_sr_d;
            r_s_sr_q  <= w_s_sr_d;
            r_carry_q <= w_carry_d;
            r_cnt_q   <= w_cnt_d;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
        end
    end

    assign bus.busy = (r_state_q == S_RUN);
    assign bus.done = (r_state_q == S_DONE);
    assign bus.sum  = r_sum_q;
    assign bus.cout = r_cout_q;

endmodule : serial_adder
`default_nettype wire
